// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the Game Boy OAM DMA controller.
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int unsigned OAM_LEN      = 160;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam int unsigned START_DELAY  = 1;
    localparam int unsigned IDX_W        = 8;
    localparam int unsigned DLY_W        = 2;

    // Sources at E0..FF alias work RAM through the echo region.
    function automatic logic [7:0] fold_src_hi(input logic [7:0] src_hi);
        return (src_hi < 8'hE0) ? src_hi : (src_hi - 8'h20);
    endfunction

endpackage

// File: rtl/dma_bus_mux.sv
// Combinational bus owner select: CPU passthrough, or DMA read cycle with CPU
// accesses below HRAM blocked.
module dma_bus_mux
    import gb_dma_pkg::*;
(
    input  logic        i_dma_own,
    input  logic [15:0] i_dma_a,
    input  logic        i_dma_cs_n,
    input  logic [15:0] i_cpu_a,
    input  logic [7:0]  i_cpu_do,
    input  logic        i_cpu_rd_n,
    input  logic        i_cpu_wr_n,
    input  logic        i_cpu_cs_n,
    input  logic [7:0]  i_bus_di,
    output logic [15:0] o_bus_a_c,
    output logic [7:0]  o_bus_do_c,
    output logic        o_bus_rd_n_c,
    output logic        o_bus_wr_n_c,
    output logic        o_bus_cs_n_c,
    output logic [7:0]  o_cpu_di_c
);

    always_comb begin
        o_bus_a_c    = i_cpu_a;
        o_bus_do_c   = i_cpu_do;
        o_bus_rd_n_c = i_cpu_rd_n;
        o_bus_wr_n_c = i_cpu_wr_n;
        o_bus_cs_n_c = i_cpu_cs_n;
        o_cpu_di_c   = i_bus_di;
        if (i_dma_own) begin
            o_bus_a_c    = i_dma_a;
            o_bus_do_c   = 8'h00;
            o_bus_rd_n_c = 1'b0;
            o_bus_wr_n_c = 1'b1;
            o_bus_cs_n_c = i_dma_cs_n;
            // HRAM/IE live on the CPU side, so those reads still complete.
            o_cpu_di_c   = (i_cpu_a >= HRAM_BASE) ? i_bus_di : 8'hFF;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: FF46 write starts a 160-byte copy from {src_hi,8'h00}
// into OAM, one byte per M-cycle, owning the shared bus while copying.
module oam_dma_ctrl
    import gb_dma_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mcycle_en,
    input  logic [15:0] cpu_A,
    input  logic [7:0]  cpu_Do,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_cs_n,
    output logic [7:0]  cpu_Di,
    output logic [15:0] A,
    output logic [7:0]  Do,
    output logic        rd_n,
    output logic        wr_n,
    output logic        cs_n,
    input  logic [7:0]  Di,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active,
    output logic [7:0]  reg_rdata
);

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [7:0]        r_src_hi;
    logic [IDX_W-1:0]  r_idx;
    logic [DLY_W-1:0]  r_delay_cnt;
    logic [7:0]        r_oam_addr;
    logic [7:0]        r_oam_wdata;
    logic              r_oam_we;

    logic              w_trigger;
    logic              w_capture;
    logic              w_last;
    logic              w_dly_done;
    logic [7:0]        w_eff_hi;
    logic              w_dma_cs_n;

    assign w_trigger  = mcycle_en & ~cpu_wr_n & (cpu_A == DMA_REG_ADDR);
    assign w_eff_hi   = fold_src_hi(r_src_hi);
    // Only A0..DF (cart RAM / WRAM) sits behind the external chip select.
    assign w_dma_cs_n = ~((w_eff_hi >= 8'hA0) && (w_eff_hi <= 8'hDF));
    assign w_last     = (r_idx == IDX_W'(OAM_LEN - 1));
    assign w_dly_done = (r_delay_cnt == DLY_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; an FF46 write restarts the sequence from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (w_trigger) begin
            w_state_nxt = DELAY;
        end else begin
            case (r_state)
                DELAY: begin
                    if (mcycle_en && w_dly_done) w_state_nxt = XFER;
                end
                XFER: begin
                    if (mcycle_en) begin
                        w_capture = 1'b1;
                        if (w_last) w_state_nxt = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_src_hi    <= 8'hFF;
            r_idx       <= '0;
            r_delay_cnt <= '0;
            r_oam_addr  <= 8'h00;
            r_oam_wdata <= 8'h00;
            r_oam_we    <= 1'b0;
        end else begin
            r_oam_we <= 1'b0;
            if (w_trigger) begin
                r_src_hi    <= cpu_Do;
                r_delay_cnt <= DLY_W'(START_DELAY);
                r_idx       <= '0;
            end else begin
                if ((r_state == DELAY) && mcycle_en) begin
                    r_delay_cnt <= r_delay_cnt - DLY_W'(1);
                end
                if (w_capture) begin
                    r_oam_wdata <= Di;
                    r_oam_addr  <= r_idx;
                    r_oam_we    <= 1'b1;
                    r_idx       <= w_last ? '0 : (r_idx + IDX_W'(1));
                end
            end
        end
    end

    dma_bus_mux u_bus_mux (
        .i_dma_own    (r_state == XFER),
        .i_dma_a      ({w_eff_hi, r_idx}),
        .i_dma_cs_n   (w_dma_cs_n),
        .i_cpu_a      (cpu_A),
        .i_cpu_do     (cpu_Do),
        .i_cpu_rd_n   (cpu_rd_n),
        .i_cpu_wr_n   (cpu_wr_n),
        .i_cpu_cs_n   (cpu_cs_n),
        .i_bus_di     (Di),
        .o_bus_a_c    (A),
        .o_bus_do_c   (Do),
        .o_bus_rd_n_c (rd_n),
        .o_bus_wr_n_c (wr_n),
        .o_bus_cs_n_c (cs_n),
        .o_cpu_di_c   (cpu_Di)
    );

    assign oam_addr   = r_oam_addr;
    assign oam_wdata  = r_oam_wdata;
    assign oam_we     = r_oam_we;
    assign dma_active = (r_state != IDLE);
    assign reg_rdata  = r_src_hi;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a bus memory model answers DMA reads,
// expected OAM writes are queued per trigger and checked by a monitor.
module tb_oam_dma_ctrl;
    import gb_dma_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] bus_a;
        logic        cs_n;
        int          strobe;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mcycle_en = 1'b0;
    logic [15:0] cpu_A;
    logic [7:0]  cpu_Do;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_cs_n;
    logic [7:0]  cpu_Di;
    logic [15:0] A;
    logic [7:0]  Do;
    logic        rd_n;
    logic        wr_n;
    logic        cs_n;
    logic [7:0]  Di;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;
    logic [7:0]  reg_rdata;

    logic [7:0]  mem [0:65535];
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_strobe = 0;
    int          n_pulses = 0;
    int          mc_cnt = 0;
    logic [15:0] cap_a = 16'h0000;
    logic        cap_cs_n = 1'b1;

    oam_dma_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mcycle_en  (mcycle_en),
        .cpu_A      (cpu_A),
        .cpu_Do     (cpu_Do),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_cs_n   (cpu_cs_n),
        .cpu_Di     (cpu_Di),
        .A          (A),
        .Do         (Do),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .cs_n       (cs_n),
        .Di         (Di),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .oam_we     (oam_we),
        .dma_active (dma_active),
        .reg_rdata  (reg_rdata)
    );

    always #5 clock = ~clock;

    assign Di = mem[A];

    // M-cycle strobe: one clock in four; n_strobe counts strobe edges seen.
    always begin
        @(posedge clock);
        if (mcycle_en) n_strobe++;
        #1;
        mc_cnt    = (mc_cnt + 1) % 4;
        mcycle_en = (mc_cnt == 3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (oam_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_oam_we: got write addr %0h expected none", oam_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("oam_addr", 32'(oam_addr), 32'(e.addr));
                chk("oam_wdata", 32'(oam_wdata), 32'(e.data));
                chk("bus_addr", 32'(cap_a), 32'(e.bus_a));
                chk("bus_cs_n", 32'(cap_cs_n), 32'(e.cs_n));
                chk("strobe_no", 32'(n_strobe), 32'(e.strobe));
            end
            n_pulses++;
        end
        if (mcycle_en) begin
            cap_a    = A;
            cap_cs_n = cs_n;
        end
    end

    task automatic push_xfer(input logic [7:0] src, input int trig);
        logic [7:0] eff;
        eff = (src < 8'hE0) ? src : (src - 8'h20);
        for (int i = 0; i < 160; i++) begin
            exp_t e;
            e.addr   = 8'(i);
            e.bus_a  = {eff, 8'(i)};
            e.data   = mem[e.bus_a];
            e.cs_n   = !((eff >= 8'hA0) && (eff <= 8'hDF));
            e.strobe = trig + 2 + i;
            sb.push_back(e);
        end
    endtask

    task automatic trigger(input logic [7:0] v);
        @(negedge clock);
        while (mcycle_en !== 1'b1) @(negedge clock);
        sb.delete();
        push_xfer(v, n_strobe + 1);
        cpu_A    = 16'hFF46;
        cpu_Do   = v;
        cpu_wr_n = 1'b0;
        cpu_cs_n = 1'b0;
        @(negedge clock);
        cpu_A    = 16'h0000;
        cpu_Do   = 8'h00;
        cpu_wr_n = 1'b1;
        cpu_cs_n = 1'b1;
        chk("dma_active_rise", 32'(dma_active), 32'd1);
    endtask

    task automatic wait_pulses(input int target);
        int n = 0;
        while (n_pulses < target && n < 800) begin
            @(negedge clock);
            n++;
        end
        if (n_pulses < target) begin
            total++;
            bad++;
            $display("FAIL timeout_pulses: got %0d expected %0d", n_pulses, target);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 800) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout_xfer: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
        chk("dma_idle_after", 32'(dma_active), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset_n  = 1'b0;
        cpu_A    = 16'h0000;
        cpu_Do   = 8'h00;
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
        cpu_cs_n = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC100 + i] = 8'(i);
            mem[16'h0200 + i] = ~8'(i);
            mem[16'hC200 + i] = 8'(i) ^ 8'hA5;
            mem[16'hC300 + i] = 8'(i * 3);
        end
        mem[16'h1234] = 8'h5C;
        mem[16'h4321] = 8'hB7;

        repeat (3) @(negedge clock);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_oam_addr", 32'(oam_addr), 32'd0);
        chk("rst_oam_wdata", 32'(oam_wdata), 32'd0);
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_reg_rdata", 32'(reg_rdata), 32'hFF);
        reset_n = 1'b1;

        // Idle passthrough
        repeat (2) @(negedge clock);
        cpu_A = 16'h1234; cpu_rd_n = 1'b0; cpu_cs_n = 1'b0;
        #1;
        chk("idle_A", 32'(A), 32'h1234);
        chk("idle_rd_n", 32'(rd_n), 32'd0);
        chk("idle_cs_n", 32'(cs_n), 32'd0);
        chk("idle_cpu_Di", 32'(cpu_Di), 32'h5C);
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; cpu_Do = 8'h9E;
        #1;
        chk("idle_wr_n", 32'(wr_n), 32'd0);
        chk("idle_Do", 32'(Do), 32'h9E);
        cpu_wr_n = 1'b1; cpu_cs_n = 1'b1; cpu_A = 16'h0000; cpu_Do = 8'h00;

        // WRAM source with CPU accesses mid-transfer
        base = n_pulses;
        trigger(8'hC1);
        wait_pulses(base + 20);
        @(negedge clock);
        cpu_A = 16'hC000; cpu_rd_n = 1'b0; cpu_cs_n = 1'b0;
        #1;
        chk("xfer_cpu_Di_blocked", 32'(cpu_Di), 32'hFF);
        chk("xfer_A_owned", 32'(A), 32'hC114);
        chk("xfer_rd_n", 32'(rd_n), 32'd0);
        chk("xfer_cs_n", 32'(cs_n), 32'd0);
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; cpu_Do = 8'h3C;
        #1;
        chk("xfer_wr_dropped", 32'(wr_n), 32'd1);
        cpu_wr_n = 1'b1; cpu_A = 16'hFF90; cpu_rd_n = 1'b0;
        #1;
        chk("xfer_hram_Di", 32'(cpu_Di), 32'd20);
        cpu_rd_n = 1'b1; cpu_cs_n = 1'b1; cpu_A = 16'h0000; cpu_Do = 8'h00;
        wait_empty();
        chk("reg_rdata_c1", 32'(reg_rdata), 32'hC1);

        // Cart ROM source: chip select stays high
        trigger(8'h02);
        wait_empty();

        // Re-trigger at idx 50 aborts and restarts from C200
        base = n_pulses;
        trigger(8'hC1);
        wait_pulses(base + 50);
        trigger(8'hC2);
        wait_empty();

        // Echo-region source folds to C300
        trigger(8'hE3);
        wait_empty();
        chk("reg_rdata_e3", 32'(reg_rdata), 32'hE3);

        // Reset during the pulse for byte 80
        trigger(8'hC1);
        n = 0;
        while (n < 800) begin
            @(posedge clock);
            #1;
            n++;
            if (oam_we === 1'b1 && oam_addr == 8'd80) break;
        end
        if (n >= 800) begin
            total++;
            bad++;
            $display("FAIL timeout_idx80: got no write at 80 expected one");
        end
        cpu_A = 16'h4321;
        reset_n = 1'b0;
        #1;
        chk("rstmid_oam_we", 32'(oam_we), 32'd0);
        chk("rstmid_dma_active", 32'(dma_active), 32'd0);
        chk("rstmid_reg_rdata", 32'(reg_rdata), 32'hFF);
        chk("rstmid_A", 32'(A), 32'h4321);
        chk("rstmid_rd_n", 32'(rd_n), 32'd1);
        chk("rstmid_cpu_Di", 32'(cpu_Di), 32'hB7);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        cpu_A = 16'h0000;
        repeat (8) @(negedge clock);
        chk("post_rst_idle", 32'(dma_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
